// File: rtl/fx2_ep_fifo.sv
// rtl/fx2_ep_fifo.sv - FX2 slave-FIFO endpoint model (OUT/IN role), byte trace when FX2_FIFO_LOG_EN is defined
module fx2_ep_fifo #(
    parameter logic [1:0] FIFOADR = 2'b00,
    parameter bit         DIR     = 1'b0,
    parameter int         DEPTH   = 512
) (
    input  logic                   ifclk,
    input  logic                   reset_n,
    input  logic [1:0]             fifoadr,
    output logic [7:0]             data,
    input  logic                   rd,
    output logic                   empty,
    input  logic [7:0]             data_in,
    input  logic                   data_wr,
    input  logic                   data_commit,
    output logic                   send_done,
    input  logic [7:0]             fd_in,
    input  logic                   wr,
    output logic                   full,
    input  logic                   pktend,
    output logic                   pkt_done,
    output logic [$clog2(DEPTH):0] pkt_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    logic [7:0]    mem [DEPTH];
    logic          sel;
    state_t        state, state_nx;
    logic [CW-1:0] stg_cnt, len, rd_ptr, stg_total;
    logic          stg_acc, commit_go, pop, last_pop;
    logic [CW-1:0] cnt, in_base, cnt_nx;
    logic          in_acc, deliver;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    assign sel = (fifoadr == FIFOADR);

    // OUT role: host staging is unaddressed; the FPGA drain needs the address match
    assign stg_acc   = !DIR && (state == S_IDLE) && data_wr && (stg_cnt < DEPTH_C);
    assign stg_total = stg_cnt + (stg_acc ? ONE_C : '0);
    assign commit_go = (state == S_IDLE) && data_commit && (stg_total != '0);
    assign pop       = (state == S_PENDING) && rd && sel;
    assign last_pop  = pop && (rd_ptr == len - ONE_C);
    assign empty     = (state != S_PENDING);
    assign data      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // OUT next-state: stage until a non-empty commit, drain until the last byte pops
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (commit_go) state_nx = S_PENDING;
            S_PENDING: if (last_pop)  state_nx = S_IDLE;
        endcase
    end

    // OUT state, staging count, drain pointer and completion pulse
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            stg_cnt   <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            send_done <= 1'b0;
        end else begin
            state     <= state_nx;
            send_done <= last_pop;
            if (last_pop)
                stg_cnt <= '0;
            else if (stg_acc)
                stg_cnt <= stg_cnt + ONE_C;
            if (commit_go) begin
                len    <= stg_total;
                rd_ptr <= '0;
            end else if (pop) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
        end
    end

    // IN role: the cycle after a delivery restarts the packet at byte 0
    assign in_acc  = DIR && sel && wr && !full;
    assign in_base = pkt_done ? '0 : cnt;
    assign cnt_nx  = in_base + (in_acc ? ONE_C : '0);
    assign deliver = DIR && ((cnt_nx == DEPTH_C) || (sel && pktend && !full));

    // IN byte count, full flag and delivery report
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            full     <= 1'b0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
        end else begin
            cnt      <= cnt_nx;
            full     <= (cnt_nx == DEPTH_C);
            pkt_done <= deliver;
            pkt_len  <= deliver ? cnt_nx : '0;
        end
    end

    assign mem_we    = stg_acc || in_acc;
    assign mem_waddr = DIR ? in_base[AW-1:0] : stg_cnt[AW-1:0];
    assign mem_wdata = DIR ? fd_in : data_in;

    // packet buffer; contents only become visible through the reset-cleared pointers
    always_ff @(posedge ifclk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

`ifdef FX2_FIFO_LOG_EN
    // byte and packet trace for the fixture log
    always @(posedge ifclk) begin
        if (reset_n) begin
            if (pop)       $display("%0t fx2_ep %0d pop %02h", $time, FIFOADR, data);
            if (in_acc)    $display("%0t fx2_ep %0d wr %02h", $time, FIFOADR, fd_in);
            if (send_done) $display("%0t fx2_ep %0d packet len=%0d", $time, FIFOADR, len);
            if (pkt_done)  $display("%0t fx2_ep %0d packet len=%0d", $time, FIFOADR, pkt_len);
        end
    end
`endif

endmodule

// File: tb/tb_fx2_ep_fifo.sv
// tb/tb_fx2_ep_fifo.sv - self-checking bench for fx2_ep_fifo (OUT and IN instances)
module tb_fx2_ep_fifo;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] fifoadr = 2'b00;
    logic       rd = 1'b0, data_wr = 1'b0, data_commit = 1'b0, wr = 1'b0, pktend = 1'b0;
    logic [7:0] data_in = 8'h00, fd_in = 8'h00;

    logic [7:0] o_data, i_data;
    logic       o_empty, o_send_done, o_full, o_pkt_done;
    logic       i_empty, i_send_done, i_full, i_pkt_done;
    logic [9:0] o_pkt_len, i_pkt_len;

    always #5 clk = ~clk;

    fx2_ep_fifo #(.FIFOADR(2'b00), .DIR(1'b0), .DEPTH(512)) u_out (
        .ifclk(clk), .reset_n(reset_n), .fifoadr(fifoadr),
        .data(o_data), .rd(rd), .empty(o_empty),
        .data_in(data_in), .data_wr(data_wr), .data_commit(data_commit), .send_done(o_send_done),
        .fd_in(fd_in), .wr(wr), .full(o_full), .pktend(pktend),
        .pkt_done(o_pkt_done), .pkt_len(o_pkt_len)
    );

    fx2_ep_fifo #(.FIFOADR(2'b10), .DIR(1'b1), .DEPTH(512)) u_in (
        .ifclk(clk), .reset_n(reset_n), .fifoadr(fifoadr),
        .data(i_data), .rd(rd), .empty(i_empty),
        .data_in(data_in), .data_wr(data_wr), .data_commit(data_commit), .send_done(i_send_done),
        .fd_in(fd_in), .wr(wr), .full(i_full), .pktend(pktend),
        .pkt_done(i_pkt_done), .pkt_len(i_pkt_len)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fifoadr = 2'b00; rd = 1'b0; data_wr = 1'b0; data_commit = 1'b0;
        wr = 1'b0; pktend = 1'b0; data_in = 8'h00; fd_in = 8'h00;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic [1:0] adr;
        logic       rd;
        logic       dwr;
        logic [7:0] din;
        logic       cmt;
        logic [7:0] e_data;
        logic       e_empty;
        logic       e_sd;
    } vec_t;

    vec_t vt [14];

    logic [7:0] stg_q[$];
    logic [7:0] pkt_q[$];
    logic [7:0] in_q[$];
    bit         m_sd, m_full, m_done, in_sel;
    int         m_len, early;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // adr, rd, data_wr, data_in, commit | data, empty, send_done (observed after the edge)
        vt[0]  = '{2'b00, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[1]  = '{2'b00, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{2'b00, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[3]  = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0};
        vt[4]  = '{2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0};
        vt[5]  = '{2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h22, 1'b0, 1'b0};
        vt[6]  = '{2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[7]  = '{2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[8]  = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[9]  = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[10] = '{2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[11] = '{2'b00, 1'b0, 1'b1, 8'hAA, 1'b1, 8'hAA, 1'b0, 1'b0};
        vt[12] = '{2'b00, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[13] = '{2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        // reset values of both roles
        idle();
        tick();
        chk("rst_out_empty", o_empty, 1);
        chk("rst_out_data", o_data, 0);
        chk("rst_out_send_done", o_send_done, 0);
        chk("rst_in_full", i_full, 0);
        chk("rst_in_pkt_done", i_pkt_done, 0);
        chk("rst_in_pkt_len", i_pkt_len, 0);
        tick();
        reset_n = 1'b1;

        // OUT directed vectors
        for (int i = 0; i < 14; i++) begin
            fifoadr = vt[i].adr; rd = vt[i].rd; data_wr = vt[i].dwr;
            data_in = vt[i].din; data_commit = vt[i].cmt;
            tick();
            chk($sformatf("vec%0d_data", i), o_data, vt[i].e_data);
            chk($sformatf("vec%0d_empty", i), o_empty, vt[i].e_empty);
            chk($sformatf("vec%0d_send_done", i), o_send_done, vt[i].e_sd);
        end
        idle();

        // OUT: asynchronous reset after 2 of 3 bytes have been popped
        data_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'hA1 + 8'(i);
            tick();
        end
        data_wr = 1'b0; data_commit = 1'b1;
        tick();
        data_commit = 1'b0; rd = 1'b1;
        tick();
        tick();
        chk("drain_before_rst_data", o_data, 8'hA3);
        rd = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_empty", o_empty, 1);
        chk("async_rst_data", o_data, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("after_rst_send_done", o_send_done, 0);
        data_commit = 1'b1;
        tick();
        chk("after_rst_commit_empty", o_empty, 1);
        idle();
        tick();

        // IN: 5 bytes then pktend, then a 2-byte packet with pktend on its last byte
        fifoadr = 2'b10;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; fd_in = 8'(i + 1);
            tick();
            chk($sformatf("in5_full_%0d", i), i_full, 0);
        end
        wr = 1'b0; pktend = 1'b1;
        tick();
        chk("in5_pkt_done", i_pkt_done, 1);
        chk("in5_pkt_len", i_pkt_len, 5);
        pktend = 1'b0;
        tick();
        chk("in5_pkt_done_end", i_pkt_done, 0);
        wr = 1'b1;
        tick();
        pktend = 1'b1;
        tick();
        chk("in2_pkt_done", i_pkt_done, 1);
        chk("in2_pkt_len", i_pkt_len, 2);
        wr = 1'b0; pktend = 1'b0;
        tick();

        // IN: full packet auto-delivery, pktend on the last byte and while full
        early = 0;
        wr = 1'b1;
        for (int i = 0; i < 511; i++) begin
            fd_in = 8'(i);
            tick();
            if (i_full || i_pkt_done) early++;
        end
        chk("in512_no_early_full", early, 0);
        pktend = 1'b1;
        tick();
        chk("in512_full", i_full, 1);
        chk("in512_pkt_done", i_pkt_done, 1);
        chk("in512_pkt_len", i_pkt_len, 512);
        tick();
        chk("in512_full_clear", i_full, 0);
        chk("in512_no_dup", i_pkt_done, 0);
        wr = 1'b0;
        tick();
        chk("in513_dropped_len", i_pkt_len, 0);
        chk("in513_zero_pkt_done", i_pkt_done, 1);
        idle();
        tick();

        // randomized traffic on both endpoints against a queue model
        do_reset();
        stg_q.delete(); pkt_q.delete(); in_q.delete();
        m_full = 0; m_done = 0; m_len = 0; m_sd = 0;
        for (int c = 0; c < 3000; c++) begin
            fifoadr     = 2'($urandom_range(0, 3));
            rd          = ($urandom_range(0, 1) == 1);
            data_wr     = ($urandom_range(0, 3) != 0);
            data_in     = 8'($urandom);
            data_commit = ($urandom_range(0, 15) == 0);
            wr          = ($urandom_range(0, 3) != 0);
            fd_in       = 8'($urandom);
            pktend      = ($urandom_range(0, 31) == 0);

            m_sd = 0;
            if (pkt_q.size() != 0) begin
                if (rd && fifoadr == 2'b00) begin
                    void'(pkt_q.pop_front());
                    m_sd = (pkt_q.size() == 0);
                end
            end else begin
                if (data_wr && stg_q.size() < 512) stg_q.push_back(data_in);
                if (data_commit && stg_q.size() != 0) begin
                    pkt_q = stg_q;
                    stg_q.delete();
                end
            end

            in_sel = (fifoadr == 2'b10);
            if (m_done) in_q.delete();
            if (in_sel && wr && !m_full) in_q.push_back(fd_in);
            m_done = (in_q.size() == 512) || (in_sel && pktend && !m_full);
            m_len  = m_done ? in_q.size() : 0;
            m_full = (in_q.size() == 512);

            tick();
            chk("rnd_out_data", o_data, (pkt_q.size() != 0) ? pkt_q[0] : 8'h00);
            chk("rnd_out_empty", o_empty, (pkt_q.size() == 0));
            chk("rnd_out_send_done", o_send_done, m_sd);
            chk("rnd_in_full", i_full, m_full);
            chk("rnd_in_pkt_done", i_pkt_done, m_done);
            chk("rnd_in_pkt_len", i_pkt_len, m_len);
            chk("rnd_out_in_role_idle", {o_full, o_pkt_done, o_pkt_len}, 0);
            chk("rnd_in_out_role_idle", {i_empty, i_send_done, i_data}, 10'h200);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fx2_ep_fifo.md
Name: fx2_ep_fifo

Overview:
- Behavioural model of one Cypress FX2 slave-FIFO endpoint, used by the FX2 test fixture.
- DIR=0 models an OUT endpoint (host→FPGA, e.g. EP2): a host-side port stages packets and the FPGA drains them with rd.
- DIR=1 models an IN endpoint (FPGA→host, e.g. EP6): the FPGA fills it with wr/pktend and the model reports completed packets on the host side.
- The endpoint responds only when the shared fifoadr bus equals its FIFOADR parameter.

Parameters:
- FIFOADR, 2'b00: endpoint address; rd, wr and pktend take effect only when fifoadr==FIFOADR.
- DIR, 0: 0 = OUT endpoint, 1 = IN endpoint. Ports of the other role are ignored and their outputs are held at reset values.
- DEPTH, 512: packet buffer size in bytes (FX2 high-speed bulk packet size).

Ports:
- ifclk  in  1  interface clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fifoadr  in  2  FIFO address select from the FPGA.
- data  out  8  (OUT) head byte of the committed packet, first-word fall-through; 0 when empty.
- rd  in  1  (OUT) active-high read strobe; pops the head byte.
- empty  out  1  (OUT) active-high; 1 when no committed bytes remain.
- data_in  in  8  (OUT, host) byte to stage.
- data_wr  in  1  (OUT, host) stage data_in.
- data_commit  in  1  (OUT, host) publish the staged bytes as one packet.
- send_done  out  1  (OUT, host) one-cycle pulse when the published packet is fully drained.
- fd_in  in  8  (IN) byte written by the FPGA.
- wr  in  1  (IN) active-high write strobe.
- full  out  1  (IN) active-high; 1 when DEPTH bytes are buffered.
- pktend  in  1  (IN) active-high; commit a short packet.
- pkt_done  out  1  (IN, host) one-cycle pulse when a packet is delivered to the host.
- pkt_len  out  $clog2(DEPTH)+1  (IN, host) byte count of the delivered packet; valid while pkt_done=1.

Behaviour:
- Reset: empty=1, full=0, send_done=0, pkt_done=0, pkt_len=0, data=0; all pointers and counts cleared; pending and staged data discarded. Reset applies immediately and asynchronously, including mid-packet.
- sel = (fifoadr==FIFOADR). rd, wr and pktend are ignored when sel=0.
- OUT states: IDLE (staging) → PENDING (draining) → IDLE.
  - In IDLE, data_wr stores data_in at stg_cnt and increments stg_cnt. Writes beyond DEPTH are dropped and stg_cnt saturates.
  - data_commit with stg_cnt>0 enters PENDING on the next edge: empty=0, rd_ptr=0, len=stg_cnt. data_commit with stg_cnt=0 is ignored.
  - In PENDING, data_wr and data_commit are ignored.
  - data always presents buf[rd_ptr] combinationally.
  - rd&sel&!empty increments rd_ptr. rd while empty is ignored.
  - On popping the last byte (rd_ptr==len-1): on the next edge empty=1, send_done pulses high for exactly one cycle, stg_cnt=0, state returns to IDLE.
  - data_wr in the same cycle as data_commit: the byte is included in the packet.
- IN role:
  - wr&sel&!full stores fd_in at cnt and increments cnt. wr while full drops the byte.
  - full = (cnt==DEPTH), registered with the write.
  - Packet delivery happens when cnt reaches DEPTH (auto-commit), or on pktend&sel (cnt may be 0: zero-length packet allowed).
  - On delivery: pkt_done=1 and pkt_len=count for one cycle; on the following edge cnt=0 and full=0.
  - wr and pktend in the same cycle: the byte is included, then committed.
  - pktend while full: a single delivery of DEPTH bytes, no duplicate.

Optional Feature:
- Macro FX2_FIFO_LOG_EN.
- When defined: the model $displays time, FIFOADR and byte value for each byte popped (OUT) or written (IN), and "packet len=N" on each send_done or pkt_done.
- When undefined: no simulation output. Functional behaviour is identical either way.

Test Plan:
- Reset → empty=1, full=0, send_done=0, pkt_done=0, data=0.
- OUT: stage 0x11,0x22,0x33, commit; drive rd with sel for 3 cycles → data reads 0x11,0x22,0x33; empty=1 and a single send_done pulse after the 3rd pop.
- OUT: rd with fifoadr≠FIFOADR while pending → rd_ptr unchanged, data stays 0x11. data_commit with no staged bytes → empty stays 1.
- IN: write 5 bytes then pktend → pkt_done pulse with pkt_len=5; full never asserted; next packet starts at count 0.
- IN: write 512 bytes → full=1 and auto-delivery with pkt_len=512; a 513th wr in the full cycle is dropped; full=0 afterwards.
- Assert reset_n=0 mid-drain (OUT, 2 of 3 bytes popped) → empty=1 immediately, no send_done, staged buffer empty.
